// File: rtl/stream_avg_pool.sv
// Streaming global average pool: one pixel (all channels) per valid beat, one averaged vector per NH*NW frame.
// Optional build macro AVGPOOL_ROUND_EN selects round-half-up instead of truncating division.
module stream_avg_pool #(
    parameter int NBITS  = 8,
    parameter int NFMAPS = 256,
    parameter int NH     = 7,
    parameter int NW     = 7
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      valid,
    input  logic [NBITS*NFMAPS-1:0]   input_act,
    output logic [NBITS*NFMAPS-1:0]   output_act,
    output logic                      ready
);

    localparam int N    = NH * NW;
    localparam int ACCW = NBITS + $clog2(N);
    localparam int CNTW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [ACCW:0]   DIV_C    = (ACCW + 1)'(N);
`ifdef AVGPOOL_ROUND_EN
    localparam logic [ACCW:0]   HALF_C   = (ACCW + 1)'(N / 2);
`endif

    // Constant divide by N; the quotient never exceeds 2^NBITS-1 so the narrowing is lossless.
    function automatic logic [NBITS-1:0] div_n(input logic [ACCW-1:0] s);
        logic [ACCW:0] num;
`ifdef AVGPOOL_ROUND_EN
        num = {1'b0, s} + HALF_C;
`else
        num = {1'b0, s};
`endif
        return NBITS'(num / DIV_C);
    endfunction

    logic [CNTW-1:0]                 pix_cnt_q, pix_cnt_d;
    logic [NFMAPS-1:0][ACCW-1:0]     acc_q, acc_d;
    logic [NFMAPS-1:0][ACCW-1:0]     sum_q, sum_d;
    logic [NFMAPS-1:0][ACCW-1:0]     tot_s;
    logic                            stage_q, stage_d;
    logic [NBITS*NFMAPS-1:0]         out_q, out_d;
    logic                            ready_q, ready_d;
    logic                            last_s;

    // Pixel counter: advances only on valid beats, wraps on the last beat of a frame.
    always_comb begin
        last_s    = valid && (pix_cnt_q == CNT_LAST);
        pix_cnt_d = pix_cnt_q;
        if (last_s) begin
            pix_cnt_d = '0;
        end else if (valid) begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Accumulate per channel; the last beat hands acc+input to the stage register and clears acc.
    always_comb begin
        acc_d   = acc_q;
        sum_d   = sum_q;
        tot_s   = '0;
        stage_d = last_s;
        for (int c = 0; c < NFMAPS; c++) begin
            tot_s[c] = acc_q[c] + ACCW'(input_act[c*NBITS +: NBITS]);
            if (last_s) begin
                acc_d[c] = '0;
                sum_d[c] = tot_s[c];
            end else if (valid) begin
                acc_d[c] = tot_s[c];
            end else begin
                acc_d[c] = acc_q[c];
            end
        end
    end

    // Divide stage: refresh the held result and pulse ready one cycle after the sum is captured.
    always_comb begin
        out_d   = out_q;
        ready_d = stage_q;
        if (stage_q) begin
            for (int c = 0; c < NFMAPS; c++) begin
                out_d[c*NBITS +: NBITS] = div_n(sum_q[c]);
            end
        end else begin
            out_d = out_q;
        end
    end

    // State registers; reset discards any partial frame and any pending result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt_q <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            stage_q   <= 1'b0;
            out_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            stage_q   <= stage_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
        end
    end

    assign output_act = out_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_stream_avg_pool.sv
// Scoreboard bench for stream_avg_pool at default parameters (7x7 frame, 256 x 8-bit channels).
module tb_stream_avg_pool;

    localparam int NBITS  = 8;
    localparam int NFMAPS = 256;
    localparam int N      = 49;
    localparam int W      = NBITS * NFMAPS;

`ifdef AVGPOOL_ROUND_EN
    localparam logic [7:0] R25 = 8'd1;
`else
    localparam logic [7:0] R25 = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid;
    logic [W-1:0]  input_act;
    logic [W-1:0]  output_act;
    logic          ready;

    typedef struct {
        logic [W-1:0] vec;
        int           edge_n;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    stream_avg_pool dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid      (valid),
        .input_act  (input_act),
        .output_act (output_act),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (rstn === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready cycle %0d got ready=1 expected 0", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc != e.edge_n) begin
                    errors++;
                    $display("FAIL %s_timing ready at cycle %0d expected cycle %0d", e.name, cyc, e.edge_n);
                end
                checks++;
                bad = -1;
                for (int c = 0; c < NFMAPS; c++) begin
                    if (bad < 0 && output_act[c*NBITS +: NBITS] !== e.vec[c*NBITS +: NBITS]) bad = c;
                end
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL %s ch%0d got %0d expected %0d", e.name, bad,
                             output_act[bad*NBITS +: NBITS], e.vec[bad*NBITS +: NBITS]);
                end
            end
        end
    end

    function automatic logic [W-1:0] fill(input int ch, input logic [7:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < NFMAPS; c++) begin
            if (ch < 0 || ch == c) r[c*NBITS +: NBITS] = v;
        end
        return r;
    endfunction

    task automatic beat(input logic [W-1:0] v, input bit push, input logic [W-1:0] ex, input string nm);
        exp_t e;
        valid     = 1'b1;
        input_act = v;
        @(posedge clk);
        #1;
        if (push) begin
            e.vec    = ex;
            e.edge_n = cyc + 1;
            e.name   = nm;
            sb.push_back(e);
        end
        valid     = 1'b0;
        input_act = '0;
    endtask

    task automatic frame_const(input logic [W-1:0] v, input string nm);
        for (int i = 0; i < N; i++) beat(v, i == N - 1, v, nm);
    endtask

    task automatic check_reset(input string nm);
        checks++;
        if (output_act !== '0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s got out_ch0=%0d ready=%0b expected 0 and 0", nm, output_act[7:0], ready);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] ex;
        rstn      = 1'b0;
        valid     = 1'b0;
        input_act = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        frame_const(fill(0, 8'd200), "ch0_200");
        repeat (3) @(posedge clk);
        #1;
        frame_const(fill(-1, 8'd255), "all_255");
        repeat (3) @(posedge clk);
        #1;

        // Sum 25 on ch1 (rounding boundary), ch3 constant 3.
        ex = fill(3, 8'd3);
        ex[15:8] = R25;
        for (int i = 0; i < N; i++) begin
            v = fill(3, 8'd3);
            if (i < 25) v[15:8] = 8'd1;
            beat(v, i == N - 1, ex, "round_sum25");
        end
        // Sum 24 on ch1 truncates/rounds to 0 in both builds.
        ex = fill(3, 8'd3);
        for (int i = 0; i < N; i++) begin
            v = fill(3, 8'd3);
            if (i < 24) v[15:8] = 8'd1;
            beat(v, i == N - 1, ex, "round_sum24");
        end
        repeat (2) @(posedge clk);
        #1;

        // Ramp 0..48 on ch2 with random idle gaps.
        for (int i = 0; i < N; i++) begin
            beat(fill(2, 8'(i)), i == N - 1, fill(2, 8'd24), "gap_ramp");
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;

        frame_const(fill(-1, 8'd10), "b2b_A");
        frame_const(fill(-1, 8'd20), "b2b_B");
        repeat (3) @(posedge clk);
        #1;

        // Abort mid-frame, then a clean frame must carry no residue.
        for (int i = 0; i < 30; i++) beat(fill(-1, 8'd100), 1'b0, '0, "");
        rstn = 1'b0;
        #1;
        check_reset("midframe_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        frame_const(fill(-1, 8'd7), "after_reset");
        repeat (3) @(posedge clk);
        #1;

        // Reset between the last beat and ready must drop the pending result.
        for (int i = 0; i < N; i++) beat(fill(-1, 8'd50), 1'b0, '0, "");
        rstn = 1'b0;
        #1;
        check_reset("pending_reset");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        frame_const(fill(5, 8'd42), "final");

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_ready got %0d outstanding results expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
